ahb_refill_arbiter: RTL and testbench
=====================================

Name: ahb_refill_arbiter

Overview:
- Arbitrates line-refill requests from up to NUM_REQ cache controllers (I-cache, D-cache, prefetcher) onto the single shared downstream AHB-lite master port.
- Sequences each granted request as one 4-beat read burst and returns the beats to the winner in arrival order.
- Uses round-robin fairness; a grant is held for the whole burst.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 32, address width
DATA_W, 32, beat width (fixed word size, hsize=3'b010)

Ports:
hclk  in  1  clock
hrst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester refill request; held high until its rsp_last
req_addr  in  NUM_REQ*ADDR_W  per-requester miss address, slice i = req i
gnt  out  NUM_REQ  one-hot grant
rsp_valid  out  1  returned beat valid (no backpressure)
rsp_data  out  DATA_W  returned beat
rsp_word  out  2  word offset within line of rsp_data
rsp_last  out  1  final beat of burst
rsp_err  out  1  burst terminated by ERROR response
haddr  out  ADDR_W  AHB address
htrans  out  2  AHB transfer type: IDLE=0, NONSEQ=2, SEQ=3
hwrite  out  1  always 0
hsize  out  3  always 3'b010
hburst  out  3  WRAP4=3'b010, INCR4=3'b011
hrdata  in  DATA_W  AHB read data
hready  in  1  AHB ready
hresp  in  1  AHB response (1=ERROR)

Behaviour:
- Interface: one clock, hclk. Reset hrst is synchronous and active-high.
- Reset values: gnt=0, rsp_*=0, htrans=IDLE, haddr=0, hburst=WRAP4, RR pointer selects req 0 first.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - If any req bit is set, pick the first set bit starting at (last_winner+1) mod NUM_REQ.
  - Latch req_addr of the winner with bits [1:0] forced to 0.
  - gnt goes one-hot the next cycle; go to ADDR.
- ADDR (address-phase beats):
  - Beat 0: htrans=NONSEQ, haddr=latched address.
  - When hready=1: issue counter increments, haddr word field [3:2] increments mod 4, [ADDR_W-1:4] is unchanged, htrans=SEQ.
  - After the 4th address is accepted (hready=1 with issue count 3): htrans=IDLE, go to DATA.
- Data capture (ADDR and DATA):
  - Beat n data is captured on the hready=1 edge following acceptance of address n (AHB pipelining).
  - Captured data appears as a registered 1-cycle rsp_valid pulse, one cycle after capture, with rsp_word = the address word offset of that beat.
  - rsp_last=1 with the 4th beat. In that same cycle the FSM returns to IDLE and gnt clears.
  - Next arbitration is evaluated in that IDLE cycle, so a back-to-back grant leaves a minimum 1-cycle htrans=IDLE gap.
- Wait states: while hready=0, haddr, htrans, and the counters hold.
- Error handling (ERR):
  - hresp=1 with hready=0 (first ERROR cycle): htrans is forced to IDLE in that same cycle (combinational override). Go to ERR.
  - In the second ERROR cycle (hready=1): emit rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0. The beat is dropped.
  - The burst is abandoned and the FSM returns to IDLE. Outstanding beats are not reissued.
- req is sampled only in IDLE. Deassertion mid-burst is ignored and the burst completes.
- The RR pointer updates to the winner at grant time. A lone requester may win repeatedly.
- hrst asserted mid-burst: all outputs take reset values at the next edge. No rsp_last is emitted; the requester must reissue.
- Counters are 2-bit. Beat and issue counts never exceed 3; address wrap is modulo 16 bytes.

Optional Feature:
REFILL_CWF_EN
- Defined (critical word first): the burst starts at the missed word offset, hburst=WRAP4, and words return in wrap order (e.g. offset 2 gives 2,3,0,1).
- Undefined: latched addr[3:0] is forced to 0, hburst=INCR4, and words return in order 0,1,2,3.

Test Plan:
- Single req0, addr 0x0000_1008, zero-wait slave, CWF on -> haddr sequence 0x1008, 0x100C, 0x1000, 0x1004; htrans N,S,S,S; rsp_word 2,3,0,1; rsp_last on the 4th beat; gnt=01 for the burst. With CWF off -> haddr 0x1000..0x100C, hburst=3'b011.
- req0 and req1 high continuously, same cycle -> grants alternate 01,10,01,10 over 4 bursts; each pair separated by ≥1 htrans=IDLE cycle.
- Slave inserts 2 wait states on beat 1 -> haddr and htrans hold for 2 cycles; rsp beats keep order with no duplicates; total rsp_valid count = 4.
- ERROR response on beat 2 (hresp=1, hready=0, then hready=1) -> htrans=IDLE in the first ERROR cycle; one rsp with rsp_err=1, rsp_last=1; 2 good beats delivered before it; FSM back to IDLE.
- hrst pulsed for 1 cycle during beat 1 -> next cycle htrans=IDLE, gnt=0, rsp_valid=0; after release, req0 is granted afresh with priority reset to req 0.
- req1 drops during its burst -> burst still completes all 4 beats; req0 (held high) is granted next.

Source files
------------

// File: rtl/ahb_refill_arbiter.sv
// ahb_refill_arbiter: round-robin line-refill arbiter onto one AHB-lite master.
// Optional critical-word-first bursts (WRAP4) when REFILL_CWF_EN is defined.
module ahb_refill_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      hclk,
  input  logic                      hrst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_word,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         haddr,
  output logic [1:0]                htrans,
  output logic                      hwrite,
  output logic [2:0]                hsize,
  output logic [2:0]                hburst,
  input  logic [DATA_W-1:0]         hrdata,
  input  logic                      hready,
  input  logic                      hresp
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;

`ifdef REFILL_CWF_EN
  localparam logic [2:0] BURST = 3'b010;
`else
  localparam logic [2:0] BURST = 3'b011;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR
  } state_t;

  state_t              state_q;
  logic [IW-1:0]       rr_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic [1:0]          htrans_q;
  logic [2:0]          hburst_q;
  logic [1:0]          icnt_q;
  logic [1:0]          bcnt_q;
  logic                dph_q;
  logic [1:0]          dword_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [1:0]          rsp_word_q;
  logic                rsp_last_q;
  logic                rsp_err_q;

  logic                win_vld;
  logic [IW-1:0]       win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [NUM_REQ-1:0]  win_oh;
  logic                err_1st;

  // Round-robin pick: first set req after the last winner
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && req[(int'(rr_q) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

`ifdef REFILL_CWF_EN
  assign win_addr = {req_addr[int'(win_idx)*ADDR_W+2 +: ADDR_W-2], 2'b00};
`else
  assign win_addr = {req_addr[int'(win_idx)*ADDR_W+4 +: ADDR_W-4], 4'b0000};
`endif

  assign win_oh = NUM_REQ'(1) << win_idx;

  // First ERROR cycle cancels the pending address in the same cycle
  assign err_1st = (state_q == S_ADDR || state_q == S_DATA) &&
                   dph_q && hresp && !hready;

  assign htrans    = err_1st ? TR_IDLE : htrans_q;
  assign haddr     = haddr_q;
  assign hburst    = hburst_q;
  assign hwrite    = 1'b0;
  assign hsize     = 3'b010;
  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

  // Grant, address issue, pipelined data capture and error abort
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q     <= S_IDLE;
      rr_q        <= IW'(NUM_REQ - 1);
      gnt_q       <= '0;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hburst_q    <= 3'b010;
      icnt_q      <= '0;
      bcnt_q      <= '0;
      dph_q       <= 1'b0;
      dword_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_word_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q    <= win_oh;
            rr_q     <= win_idx;
            haddr_q  <= win_addr;
            htrans_q <= TR_NSEQ;
            hburst_q <= BURST;
            icnt_q   <= '0;
            bcnt_q   <= '0;
            dph_q    <= 1'b0;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR, S_DATA: begin
          if (err_1st) begin
            htrans_q <= TR_IDLE;
            state_q  <= S_ERR;
          end else if (hready) begin
            if (dph_q) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= hrdata;
              rsp_word_q  <= dword_q;
              bcnt_q      <= bcnt_q + 2'd1;
              if (bcnt_q == 2'd3) begin
                rsp_last_q <= 1'b1;
                gnt_q      <= '0;
                state_q    <= S_IDLE;
              end
            end
            if (state_q == S_ADDR) begin
              dph_q   <= 1'b1;
              dword_q <= haddr_q[3:2];
              if (icnt_q == 2'd3) begin
                htrans_q <= TR_IDLE;
                state_q  <= S_DATA;
              end else begin
                icnt_q       <= icnt_q + 2'd1;
                haddr_q[3:2] <= haddr_q[3:2] + 2'd1;
                htrans_q     <= TR_SEQ;
              end
            end else begin
              dph_q <= 1'b0;
            end
          end
        end
        S_ERR: begin
          if (hready) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_last_q  <= 1'b1;
            rsp_data_q  <= '0;
            rsp_word_q  <= dword_q;
            gnt_q       <= '0;
            dph_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_refill_arbiter.sv
// tb_ahb_refill_arbiter: scoreboard bench for the AHB refill arbiter.
// Expected addresses and beats are queued at stimulus time.
module tb_ahb_refill_arbiter;

  logic        hclk = 1'b0;
  logic        hrst;
  logic [1:0]  req;
  logic [63:0] req_addr;
  logic [1:0]  gnt;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_word;
  logic        rsp_last;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

`ifdef REFILL_CWF_EN
  localparam logic [2:0] BURST = 3'b010;
`else
  localparam logic [2:0] BURST = 3'b011;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  tr;
    logic [1:0]  g;
  } ea_t;

  typedef struct packed {
    logic [1:0]  w;
    logic        chkw;
    logic [31:0] d;
    logic        last;
    logic        err;
  } er_t;

  ea_t qa[$];
  er_t qr[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  n_rsp = 0;

  logic        dp_v;
  logic [31:0] dp_a;

  ahb_refill_arbiter #(
    .NUM_REQ(2),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .hclk     (hclk),
    .hrst     (hrst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_word (rsp_word),
    .rsp_last (rsp_last),
    .rsp_err  (rsp_err),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hrdata   (hrdata),
    .hready   (hready),
    .hresp    (hresp)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] sdat(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input int k);
    logic [1:0] w;
`ifdef REFILL_CWF_EN
    w = a[3:2] + 2'(k);
`else
    w = 2'(k);
`endif
    return {a[31:4], w, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input int who, input logic [31:0] a, input int n);
    ea_t e;
    for (int k = 0; k < n; k++) begin
      e.a  = baddr(a, k);
      e.tr = (k == 0) ? 2'b10 : 2'b11;
      e.g  = 2'(1 << who);
      qa.push_back(e);
    end
  endtask

  task automatic push_r(input logic [31:0] a, input int n, input bit full);
    er_t e;
    logic [31:0] ba;
    for (int k = 0; k < n; k++) begin
      ba     = baddr(a, k);
      e.w    = ba[3:2];
      e.chkw = 1'b1;
      e.d    = sdat(ba);
      e.last = full && (k == 3);
      e.err  = 1'b0;
      qr.push_back(e);
    end
  endtask

  task automatic push_burst(input int who, input logic [31:0] a);
    push_a(who, a, 4);
    push_r(a, 4, 1'b1);
  endtask

  task automatic cyc();
    @(posedge hclk);
    #2;
  endtask

  task automatic do_reset();
    hrst = 1'b1;
    req  = 2'b00;
    cyc();
    cyc();
    hrst = 1'b0;
  endtask

  task automatic wait_last(input logic [1:0] drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge hclk);
      if (rsp_valid && rsp_last) seen = 1'b1;
    end
    chk("last_seen", 32'(seen), 1);
    chk("gap_htrans", 32'(htrans), 0);
    req = req & ~drop;
  endtask

  // AHB slave: data phase follows an accepted address
  always @(posedge hclk) begin
    if (hrst) begin
      dp_v <= 1'b0;
      dp_a <= '0;
    end else if (hready) begin
      dp_v <= htrans[1];
      dp_a <= haddr;
    end
  end

  assign hrdata = dp_v ? sdat(dp_a) : 32'h0;

  // Monitor: pop address and beat expectations
  initial begin
    logic [1:0] ptr;
    ea_t ea;
    er_t er;
    ptr = 2'b00;
    forever begin
      @(negedge hclk);
      if (rsp_valid) begin
        n_rsp++;
        if (qr.size() == 0) begin
          chk("rsp_extra", 1, 0);
        end else begin
          er = qr.pop_front();
          chk("rsp_data", rsp_data, er.d);
          if (er.chkw) chk("rsp_word", 32'(rsp_word), 32'(er.w));
          chk("rsp_last", 32'(rsp_last), 32'(er.last));
          chk("rsp_err", 32'(rsp_err), 32'(er.err));
        end
      end
      if (htrans != 2'b00 && hready) begin
        if (qa.size() == 0) begin
          chk("addr_extra", 1, 0);
        end else begin
          ea = qa.pop_front();
          chk("haddr", haddr, ea.a);
          chk("htrans", 32'(htrans), 32'(ea.tr));
          chk("gnt", 32'(gnt), 32'(ea.g));
          chk("hburst", 32'(hburst), 32'(BURST));
        end
      end
      if (htrans == 2'b10 && ptr != 2'b10)
        chk("idle_gap", 32'(ptr), 0);
      ptr = htrans;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    er_t ee;
    hrst     = 1'b1;
    req      = 2'b00;
    req_addr = '0;
    hready   = 1'b1;
    hresp    = 1'b0;
    cyc();
    cyc();
    @(negedge hclk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_htrans", 32'(htrans), 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hburst", 32'(hburst), 32'h2);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_last", 32'(rsp_last), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_data", rsp_data, 0);
    cyc();
    hrst = 1'b0;

    // single request, zero wait states
    req_addr = {32'h0, 32'h0000_1008};
    push_burst(0, 32'h0000_1008);
    req = 2'b01;
    cyc();
    @(negedge hclk);
    chk("hsize", 32'(hsize), 32'h2);
    chk("hwrite", 32'(hwrite), 0);
    chk("gnt_t1", 32'(gnt), 32'h1);
    wait_last(2'b01);
    cyc();
    cyc();

    // two requesters alternate
    do_reset();
    req_addr = {32'h0000_3038, 32'h0000_2004};
    push_burst(0, 32'h0000_2004);
    push_burst(1, 32'h0000_3038);
    push_burst(0, 32'h0000_2004);
    push_burst(1, 32'h0000_3038);
    req = 2'b11;
    wait_last(2'b00);
    wait_last(2'b00);
    wait_last(2'b00);
    wait_last(2'b11);
    cyc();

    // two wait states on beat 1
    do_reset();
    req_addr = {32'h0, 32'h0000_4004};
    push_burst(0, 32'h0000_4004);
    n0  = n_rsp;
    req = 2'b01;
    cyc();
    cyc();
    cyc();
    hready = 1'b0;
    @(negedge hclk);
    chk("ws_haddr0", haddr, baddr(32'h0000_4004, 2));
    chk("ws_htrans0", 32'(htrans), 32'h3);
    cyc();
    @(negedge hclk);
    chk("ws_haddr1", haddr, baddr(32'h0000_4004, 2));
    chk("ws_htrans1", 32'(htrans), 32'h3);
    cyc();
    hready = 1'b1;
    wait_last(2'b01);
    cyc();
    chk("rsp_cnt", 32'(n_rsp - n0), 4);

    // ERROR response on beat 2
    do_reset();
    req_addr = {32'h0, 32'h0000_5008};
    push_a(0, 32'h0000_5008, 3);
    push_r(32'h0000_5008, 2, 1'b0);
    ee.w    = 2'b00;
    ee.chkw = 1'b0;
    ee.d    = 32'h0;
    ee.last = 1'b1;
    ee.err  = 1'b1;
    qr.push_back(ee);
    req = 2'b01;
    cyc();
    cyc();
    cyc();
    cyc();
    hresp  = 1'b1;
    hready = 1'b0;
    @(negedge hclk);
    chk("err_htrans", 32'(htrans), 0);
    cyc();
    hready = 1'b1;
    cyc();
    hresp = 1'b0;
    wait_last(2'b01);
    @(negedge hclk);
    chk("err_gnt", 32'(gnt), 0);

    // reset pulse during beat 1
    do_reset();
    req_addr = {32'h0000_7010, 32'h0000_6000};
    push_a(0, 32'h0000_6000, 2);
    push_burst(0, 32'h0000_6000);
    push_burst(1, 32'h0000_7010);
    req = 2'b11;
    cyc();
    cyc();
    hrst = 1'b1;
    cyc();
    hrst = 1'b0;
    @(negedge hclk);
    chk("mrst_htrans", 32'(htrans), 0);
    chk("mrst_gnt", 32'(gnt), 0);
    chk("mrst_rsp", 32'(rsp_valid), 0);
    wait_last(2'b01);
    wait_last(2'b10);

    // requester drops mid-burst
    do_reset();
    req_addr = {32'h0000_8024, 32'h0000_9000};
    push_burst(1, 32'h0000_8024);
    push_burst(0, 32'h0000_9000);
    req = 2'b10;
    cyc();
    req = 2'b01;
    wait_last(2'b00);
    wait_last(2'b01);

    cyc();
    cyc();
    cyc();
    chk("addr_q_left", 32'(qa.size()), 0);
    chk("rsp_q_left", 32'(qr.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
